// File: rtl/noc_local_inject_queue.sv
// Local-port injection FIFO feeding the router P input under stop/void flow control.
// Optional store-and-forward holds a packet back until its tail is buffered or the FIFO fills.
module noc_local_inject_queue #(
  parameter int unsigned Width        = 66,
  parameter int unsigned Depth        = 4,
  parameter bit          StoreForward = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [Width-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [Width-1:0]             out_data,
  output logic                         out_void,
  input  logic                         stop_in,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW    = $clog2(Depth);
  localparam int unsigned CntW    = $clog2(Depth + 1);
  localparam int unsigned TailBit = Width - 2;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [CntW-1:0]  pkts_q, pkts_d;

  logic full;
  logic rel;
  logic enq;
  logic deq;
  logic in_tail;
  logic out_tail;

  assign full     = (count_q == CntW'(Depth));
  assign in_ready = rst & ~full;
  assign out_data = mem_q[rd_ptr_q];
  assign in_tail  = in_data[TailBit];
  assign out_tail = out_data[TailBit];

  // Full override lets packets longer than Depth degrade to cut-through.
  assign rel      = ~StoreForward | (pkts_q != '0) | full;
  assign out_void = ~((count_q != '0) & rel);
  assign enq      = in_valid & in_ready;
  assign deq      = ~out_void & ~stop_in;
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pkts_d   = pkts_q;
    if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    case ({enq & in_tail, deq & out_tail})
      2'b10:   pkts_d = pkts_q + CntW'(1);
      2'b01:   pkts_d = pkts_q - CntW'(1);
      default: pkts_d = pkts_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pkts_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pkts_q   <= pkts_d;
    end
  end

  // Flit storage is not reset; validity is carried by count_q.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_noc_local_inject_queue.sv
// Randomized bench for noc_local_inject_queue: one cut-through and one store-and-forward
// instance, each compared every cycle against a list-based reference model.
module tb_noc_local_inject_queue;

  localparam int W  = 66;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam int SN = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rst_next;
  logic [W-1:0]  in_data_s  [2];
  logic          in_valid_s [2];
  logic          stop_s     [2];
  logic          in_ready_w [2];
  logic          out_void_w [2];
  logic [W-1:0]  out_data_w [2];
  logic [CW-1:0] count_w    [2];

  noc_local_inject_queue #(.Width(W), .Depth(D), .StoreForward(1'b0)) u_ct (
    .clk(clk), .rst(rst), .in_data(in_data_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_w[0]), .out_data(out_data_w[0]), .out_void(out_void_w[0]),
    .stop_in(stop_s[0]), .count(count_w[0]));

  noc_local_inject_queue #(.Width(W), .Depth(D), .StoreForward(1'b1)) u_sf (
    .clk(clk), .rst(rst), .in_data(in_data_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_w[1]), .out_data(out_data_w[1]), .out_void(out_void_w[1]),
    .stop_in(stop_s[1]), .count(count_w[1]));

  // Reference model: stored flits as an ordered list, oldest at index 0.
  logic [W-1:0] mem [2][D];
  int           msize [2];
  logic [W-1:0] src [2][SN];
  int           src_n [2];
  int           src_i [2];
  int           gap_left [2];
  int           p_valid, p_stop, gap_cfg;
  int           n_tests, n_fail;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_void(input int d);
    logic r;
    if (msize[d] == 0) return 1'b1;
    r = (d == 0) || (msize[d] == D);
    for (int i = 0; i < msize[d]; i++) if (mem[d][i][W-2]) r = 1'b1;
    return !r;
  endfunction

  function automatic logic exp_ready(input int d);
    return rst && (msize[d] != D);
  endfunction

  function automatic logic [W-1:0] make_flit(input logic h, input logic t, input int pay);
    return {h, t, 64'(pay)};
  endfunction

  task automatic clear_src(input int d);
    src_n[d] = 0;
    src_i[d] = 0;
    gap_left[d] = 0;
  endtask

  task automatic load_pkt(input int d, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      src[d][src_n[d]] = make_flit(i == 0, i == n - 1, base + i);
      src_n[d]++;
    end
  endtask

  task automatic step();
    logic enq [2];
    logic deq [2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check(d ? "sf_ready" : "ct_ready", W'(in_ready_w[d]), W'(exp_ready(d)));
      check(d ? "sf_void" : "ct_void", W'(out_void_w[d]), W'(exp_void(d)));
      check(d ? "sf_count" : "ct_count", W'(count_w[d]), W'(msize[d]));
      if (!exp_void(d)) check(d ? "sf_data" : "ct_data", out_data_w[d], mem[d][0]);
    end
    rst = rst_next;
    for (int d = 0; d < 2; d++) begin
      if (src_i[d] < src_n[d]) begin
        in_data_s[d]  = src[d][src_i[d]];
        in_valid_s[d] = (gap_left[d] == 0) && ($urandom_range(99) < p_valid);
      end else begin
        in_data_s[d]  = {$urandom, $urandom, $urandom};
        in_valid_s[d] = 1'b0;
      end
      stop_s[d] = ($urandom_range(99) < p_stop);
      enq[d] = in_valid_s[d] && exp_ready(d);
      deq[d] = !exp_void(d) && !stop_s[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (deq[d]) begin
        for (int i = 0; i < D - 1; i++) mem[d][i] = mem[d][i+1];
        msize[d]--;
      end
      if (gap_left[d] > 0) gap_left[d]--;
      if (enq[d]) begin
        mem[d][msize[d]] = src[d][src_i[d]];
        msize[d]++;
        src_i[d]++;
        gap_left[d] = gap_cfg;
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int  cyc;
    logic done;
    cyc = 0;
    done = 1'b0;
    while (cyc < budget && !done) begin
      step();
      cyc++;
      done = (src_i[0] == src_n[0]) && (msize[0] == 0) &&
             (src_i[1] == src_n[1]) && (msize[1] == 0);
    end
    check(tag, W'(done), W'(1));
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    p_valid = 100; p_stop = 0; gap_cfg = 0;
    rst = 1'b0; rst_next = 1'b0;
    for (int d = 0; d < 2; d++) begin
      msize[d] = 0;
      clear_src(d);
      in_data_s[d] = '0; in_valid_s[d] = 1'b0; stop_s[d] = 1'b0;
    end

    // Reset held with the source pushing: nothing may enter.
    for (int d = 0; d < 2; d++) load_pkt(d, 4, 'h100);
    repeat (3) step();
    rst_next = 1'b1;
    drain("reset_release_drain", 100);

    // Back-to-back 8-flit packet, payloads 1..8.
    for (int d = 0; d < 2; d++) begin clear_src(d); load_pkt(d, 8, 1); end
    drain("stream_drain", 100);

    // Router stalls: FIFO fills, last flits wait at the source.
    for (int d = 0; d < 2; d++) begin clear_src(d); load_pkt(d, 6, 'h20); end
    p_stop = 100;
    repeat (10) step();
    check("bp_full_ct", W'(count_w[0]), W'(4));
    check("bp_full_sf", W'(count_w[1]), W'(4));
    p_stop = 0;
    drain("bp_drain", 100);

    // Sparse 3-flit packet exercising store-and-forward gating.
    for (int d = 0; d < 2; d++) begin clear_src(d); load_pkt(d, 3, 'h40); end
    gap_cfg = 2;
    drain("sf_gap_drain", 100);
    gap_cfg = 0;

    // Asynchronous reset with three flits stored.
    for (int d = 0; d < 2; d++) begin clear_src(d); load_pkt(d, 3, 'h60); end
    p_stop = 100;
    repeat (6) step();
    #2 rst = 1'b0; rst_next = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check(d ? "sf_rst_void" : "ct_rst_void", W'(out_void_w[d]), W'(1));
      check(d ? "sf_rst_count" : "ct_rst_count", W'(count_w[d]), W'(0));
      check(d ? "sf_rst_ready" : "ct_rst_ready", W'(in_ready_w[d]), W'(0));
      msize[d] = 0;
      clear_src(d);
    end
    p_stop = 0;
    repeat (2) step();
    rst_next = 1'b1;
    step();

    // Random packets with random source gaps and router stalls.
    p_valid = 70; p_stop = 30;
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++) begin
        if (src_i[d] == src_n[d] && src_n[d] < SN - 8) load_pkt(d, $urandom_range(1, 6), 'h1000 + k * 8);
      end
      step();
    end
    p_valid = 100; p_stop = 0;
    drain("random_drain", 500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
